// File: rtl/uart_pkg.sv
// Shared constants, FSM encoding and frame byte helper for the UART frame arbiter.
package uart_pkg;

    localparam int FRAME_W   = 40;
    localparam int NUM_BYTES = 5;
    localparam int NUM_REQ   = 3;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ARB    = 3'd1,
        LOAD   = 3'd2,
        STROBE = 3'd3,
        WAIT   = 3'd4,
        DONE   = 3'd5
    } state_t;

    // Byte 0 is the address, sent first; the 24-bit payload goes out MSB first.
    function automatic logic [7:0] frame_byte(input logic [FRAME_W-1:0] f,
                                              input logic [2:0]         idx);
        logic [7:0] b;
        case (idx)
            3'd0:    b = f[39:32];
            3'd1:    b = f[31:24];
            3'd2:    b = f[23:16];
            3'd3:    b = f[15:8];
            3'd4:    b = f[7:0];
            default: b = 8'h00;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: searches upward from last_grant+1, modulo NUM_REQ.
module rr_pick
    import uart_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [1:0]         last_grant,
    output logic [1:0]         winner,
    output logic               valid
);

    // Walk the candidates farthest-first so the nearest requester overwrites last.
    always_comb begin
        winner = 2'd0;
        valid  = 1'b0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            int cand;
            cand = (int'(last_grant) + k) % NUM_REQ;
            if (req[cand]) begin
                winner = 2'(cand);
                valid  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_frame_arbiter.sv
// Arbitrates three 5-byte frame requesters onto one shared uart_send, one byte per slot.
module uart_frame_arbiter #(
    parameter logic [15:0] SLOT_CYC  = 16'd8680,
    parameter int          NUM_BYTES = 5
) (
    input  logic                                        sys_clk,
    input  logic                                        sys_rst,
    input  logic [uart_pkg::NUM_REQ-1:0]                req,
    input  logic [uart_pkg::NUM_REQ*uart_pkg::FRAME_W-1:0] frame,
    output logic [uart_pkg::NUM_REQ-1:0]                grant,
    output logic                                        busy,
    output logic [7:0]                                  tx_byte,
    output logic                                        tx_byte_en
);

    localparam int NREQ = uart_pkg::NUM_REQ;
    localparam int FW   = uart_pkg::FRAME_W;

    uart_pkg::state_t state_reg, state_next;
    logic [1:0]       last_grant_reg, last_grant_next;
    logic [2:0]       byte_idx_reg, byte_idx_next;
    logic [15:0]      slot_cnt_reg, slot_cnt_next;
    logic [FW-1:0]    frame_reg, frame_next;
    logic [7:0]       tx_byte_reg, tx_byte_next;

    logic [FW-1:0]    frames [NREQ];
    logic [1:0]       winner;
    logic             win_valid;

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_frames
            assign frames[gi] = frame[gi*FW +: FW];
        end
    endgenerate

    rr_pick u_rr_pick (
        .req        (req),
        .last_grant (last_grant_reg),
        .winner     (winner),
        .valid      (win_valid)
    );

    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            state_reg      <= uart_pkg::IDLE;
            last_grant_reg <= 2'd2;
            byte_idx_reg   <= 3'd0;
            slot_cnt_reg   <= 16'd0;
            frame_reg      <= '0;
            tx_byte_reg    <= 8'h00;
        end else begin
            state_reg      <= state_next;
            last_grant_reg <= last_grant_next;
            byte_idx_reg   <= byte_idx_next;
            slot_cnt_reg   <= slot_cnt_next;
            frame_reg      <= frame_next;
            tx_byte_reg    <= tx_byte_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        last_grant_next = last_grant_reg;
        byte_idx_next   = byte_idx_reg;
        slot_cnt_next   = slot_cnt_reg;
        frame_next      = frame_reg;
        tx_byte_next    = tx_byte_reg;
        grant           = '0;
        busy            = 1'b0;
        tx_byte_en      = 1'b0;

        case (state_reg)
            uart_pkg::IDLE: begin
                if (|req) begin
                    state_next = uart_pkg::ARB;
                end
            end
            uart_pkg::ARB: begin
                // A request dropped between IDLE and ARB yields no grant.
                if (win_valid) begin
                    grant           = {{(NREQ-1){1'b0}}, 1'b1} << winner;
                    busy            = 1'b1;
                    frame_next      = frames[winner];
                    last_grant_next = winner;
                    byte_idx_next   = 3'd0;
                    state_next      = uart_pkg::LOAD;
                end else begin
                    state_next = uart_pkg::IDLE;
                end
            end
            uart_pkg::LOAD: begin
                busy         = 1'b1;
                tx_byte_next = uart_pkg::frame_byte(frame_reg, byte_idx_reg);
                state_next   = uart_pkg::STROBE;
            end
            uart_pkg::STROBE: begin
                busy          = 1'b1;
                tx_byte_en    = 1'b1;
                slot_cnt_next = 16'd0;
                state_next    = uart_pkg::WAIT;
            end
            uart_pkg::WAIT: begin
                busy = 1'b1;
                if (slot_cnt_reg == SLOT_CYC - 16'd1) begin
                    slot_cnt_next = 16'd0;
                    byte_idx_next = byte_idx_reg + 3'd1;
                    if (byte_idx_reg < 3'(NUM_BYTES - 1)) begin
                        state_next = uart_pkg::LOAD;
                    end else begin
                        state_next = uart_pkg::DONE;
                    end
                end else begin
                    slot_cnt_next = slot_cnt_reg + 16'd1;
                end
            end
            uart_pkg::DONE: begin
                state_next = uart_pkg::IDLE;
            end
            default: begin
                state_next = uart_pkg::IDLE;
            end
        endcase
    end

    assign tx_byte = tx_byte_reg;

endmodule

// File: tb/tb_uart_frame_arbiter.sv
// Scoreboard bench for uart_frame_arbiter with a short byte slot.
module tb_uart_frame_arbiter;

    localparam logic [15:0] SLOT = 16'd20;
    localparam int          GAP  = 22;

    localparam logic [39:0] F0 = 40'h01_02_A5B6C7;
    localparam logic [39:0] F1 = 40'h11_22_334455;
    localparam logic [39:0] F2 = 40'hA0_B0_C0D0E0;

    logic         sys_clk = 1'b0;
    logic         sys_rst = 1'b0;
    logic [2:0]   req     = 3'b000;
    logic [119:0] frame   = '0;
    logic [2:0]   grant;
    logic         busy;
    logic [7:0]   tx_byte;
    logic         tx_byte_en;

    int checks    = 0;
    int failures  = 0;
    int cyc       = 0;
    int grant_cnt = 0;
    int en_cnt    = 0;
    int last_en_cyc = 0;
    int in_frame  = 0;

    logic [2:0] exp_grant_q [$];
    logic [7:0] exp_byte_q  [$];

    uart_frame_arbiter #(
        .SLOT_CYC  (SLOT),
        .NUM_BYTES (5)
    ) dut (
        .sys_clk    (sys_clk),
        .sys_rst    (sys_rst),
        .req        (req),
        .frame      (frame),
        .grant      (grant),
        .busy       (busy),
        .tx_byte    (tx_byte),
        .tx_byte_en (tx_byte_en)
    );

    always #5 sys_clk = ~sys_clk;

    always @(posedge sys_clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic push_frame(input int r, input logic [39:0] f);
        exp_grant_q.push_back(3'b001 << r);
        for (int i = 0; i < 5; i++) begin
            exp_byte_q.push_back(f[39-8*i -: 8]);
        end
    endtask

    // Scoreboard side: every grant and byte strobe is matched against the queues.
    always @(negedge sys_clk) begin
        if (!sys_rst) begin
            in_frame = 0;
        end else begin
            if (grant != 3'b000) begin
                logic [31:0] eg;
                grant_cnt++;
                in_frame = 0;
                eg = (exp_grant_q.size() > 0) ? {29'd0, exp_grant_q.pop_front()} : 32'hDEAD;
                $display("grant %b at cycle %0d", grant, cyc);
                check("grant", {29'd0, grant}, eg);
                check("grant_onehot", $countones(grant), 1);
            end
            if (tx_byte_en) begin
                logic [31:0] eb;
                en_cnt++;
                eb = (exp_byte_q.size() > 0) ? {24'd0, exp_byte_q.pop_front()} : 32'hDEAD;
                $display("byte %02h at cycle %0d", tx_byte, cyc);
                check("byte", {24'd0, tx_byte}, eb);
                if (in_frame > 0) check("byte_gap", cyc - last_en_cyc, GAP);
                last_en_cyc = cyc;
                in_frame++;
            end
        end
    end

    task automatic wait_grants(input int n, input int limit);
        int t = 0;
        while (grant_cnt < n && t < limit) begin
            @(negedge sys_clk); #1;
            t++;
        end
        check("wait_grant", grant_cnt, n);
    endtask

    task automatic wait_en(input int n, input int limit);
        int t = 0;
        while (en_cnt < n && t < limit) begin
            @(negedge sys_clk); #1;
            t++;
        end
        check("wait_en", en_cnt, n);
    endtask

    // Requests must stay up through the ARB cycle, so drop them after the next edge.
    task automatic grant_then_drop(input int n, input logic [2:0] mask);
        wait_grants(n, 400);
        @(posedge sys_clk); #1;
        req = req & ~mask;
    endtask

    task automatic settle_and_drain(input string tag);
        repeat (30) @(negedge sys_clk);
        #1;
        check({tag, "_grant_q"}, exp_grant_q.size(), 0);
        check({tag, "_byte_q"}, exp_byte_q.size(), 0);
    endtask

    task automatic do_reset(input logic [2:0] req_val);
        #1 sys_rst = 1'b0;
        exp_grant_q.delete();
        exp_byte_q.delete();
        req = req_val;
        repeat (3) @(negedge sys_clk);
        sys_rst = 1'b1;
    endtask

    initial begin
        int g, e, d, n;
        frame = {F2, F1, F0};

        @(negedge sys_clk); #1;
        check("rst_grant", grant, 3'b000);
        check("rst_busy", busy, 1'b0);
        check("rst_tx_byte", tx_byte, 8'h00);
        check("rst_tx_en", tx_byte_en, 1'b0);
        @(negedge sys_clk);
        sys_rst = 1'b1;

        // Single frame, with busy falling one cycle after the last slot.
        push_frame(0, F0);
        req = 3'b001;
        grant_then_drop(grant_cnt + 1, 3'b001);
        wait_en(5, 300);
        n = 0;
        while (busy && n < 50) begin
            @(negedge sys_clk); #1;
            n++;
        end
        check("busy_fall", n, GAP - 1);
        settle_and_drain("single");

        // Three-way contention held from reset release.
        do_reset(3'b111);
        g = grant_cnt; e = en_cnt;
        push_frame(0, F0); push_frame(1, F1); push_frame(2, F2);
        grant_then_drop(g + 1, 3'b001);
        grant_then_drop(g + 2, 3'b010);
        grant_then_drop(g + 3, 3'b100);
        wait_en(e + 15, 600);
        settle_and_drain("contend");

        // Two persistent requesters must alternate.
        do_reset(3'b101);
        g = grant_cnt; e = en_cnt;
        push_frame(0, F0); push_frame(2, F2); push_frame(0, F0); push_frame(2, F2);
        grant_then_drop(g + 4, 3'b101);
        wait_en(e + 20, 800);
        settle_and_drain("fair");

        // Frame and request changes mid-frame do not disturb the latched frame.
        do_reset(3'b000);
        g = grant_cnt; e = en_cnt;
        push_frame(0, F0);
        req = 3'b001;
        grant_then_drop(g + 1, 3'b001);
        wait_en(e + 3, 200);
        frame[39:0] = 40'hFF_EE_DDCCBB;
        push_frame(1, F1);
        req = 3'b010;
        n = 0;
        while (busy && n < 200) begin
            @(negedge sys_clk); #1;
            n++;
        end
        d = cyc;
        wait_grants(g + 2, 20);
        check("rearb_gap", cyc - d, 2);
        @(posedge sys_clk); #1;
        req = 3'b000;
        wait_en(e + 10, 300);
        settle_and_drain("midframe");
        frame[39:0] = F0;

        // Asynchronous reset in the middle of byte 3's slot.
        do_reset(3'b000);
        g = grant_cnt; e = en_cnt;
        push_frame(0, F0);
        req = 3'b001;
        grant_then_drop(g + 1, 3'b001);
        wait_en(e + 4, 200);
        repeat (5) @(negedge sys_clk);
        #2 sys_rst = 1'b0;
        #1;
        check("midrst_grant", grant, 3'b000);
        check("midrst_busy", busy, 1'b0);
        check("midrst_tx_byte", tx_byte, 8'h00);
        check("midrst_tx_en", tx_byte_en, 1'b0);
        exp_grant_q.delete();
        exp_byte_q.delete();
        e = en_cnt;
        repeat (3) @(negedge sys_clk);
        sys_rst = 1'b1;
        repeat (40) @(negedge sys_clk);
        #1;
        check("no_en_after_rst", en_cnt, e);
        g = grant_cnt;
        push_frame(1, F1);
        req = 3'b010;
        grant_then_drop(g + 1, 3'b010);
        wait_en(e + 5, 300);
        settle_and_drain("after_rst");

        // One-cycle request pulse: ARB is entered but nothing is granted.
        g = grant_cnt; e = en_cnt;
        @(negedge sys_clk);
        req = 3'b001;
        @(posedge sys_clk); #1;
        req = 3'b000;
        @(negedge sys_clk); #1;
        check("withdraw_busy", busy, 1'b0);
        check("withdraw_grant_now", grant, 3'b000);
        repeat (30) @(negedge sys_clk);
        #1;
        check("withdraw_grants", grant_cnt, g);
        check("withdraw_en", en_cnt, e);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_frame_arbiter.md
UART_FRAME_ARBITER -- requirements
Module: uart_frame_arbiter

Interface
REQ-001 Parameter SLOT_CYC, default 16'd8680: clocks reserved per transmitted byte (2 x 10 x BPS_CNT at BPS_CNT=434).
REQ-002 Parameter NUM_BYTES, default 5: bytes per frame, fixed at 5.
REQ-003 sys_clk  input  1  system clock; all logic on the rising edge.
REQ-004 sys_rst  input  1  reset, asynchronous, active-low.
REQ-005 req  input  3  per-requester frame request; level, held until that requester's grant pulse.
REQ-006 frame  input  120  three 40-bit frames; requester i uses bits [40i+39:40i], laid out {addr[7:0], mod_sel[7:0], d[23:0]}.
REQ-007 grant  output  3  one-hot, single-cycle pulse: frame of requester i is latched.
REQ-008 busy  output  1  high from grant until the last byte slot ends.
REQ-009 tx_byte  output  8  byte presented to the shared uart_send.
REQ-010 tx_byte_en  output  1  single-cycle pulse; uart_send starts a byte on its rising edge.

Function
REQ-011 FSM states: IDLE, ARB, LOAD, STROBE, WAIT, DONE.
REQ-012 IDLE: stay while req==0; go to ARB on the first cycle any req bit is high.
REQ-013 ARB (1 cycle): select a requester round-robin, searching upward from last_grant+1 modulo 3.
REQ-014 ARB, same cycle: latch the winner's 40-bit frame, pulse grant[winner], update last_grant, clear byte_idx, go to LOAD.
REQ-015 ARB with req==0 (request withdrawn): no grant, return to IDLE.
REQ-016 LOAD (1 cycle): drive tx_byte with byte byte_idx of the latched frame (idx 0=addr, 1=mod_sel, 2=d[23:16], 3=d[15:8], 4=d[7:0]); tx_byte_en=0.
REQ-017 STROBE (1 cycle): tx_byte_en=1, tx_byte unchanged; go to WAIT.
REQ-018 WAIT: slot counter runs from 0 to SLOT_CYC-1 with tx_byte held stable.
REQ-019 At the end of WAIT: increment byte_idx; go to LOAD if byte_idx < NUM_BYTES-1, otherwise go to DONE.
REQ-020 Timing: LOAD-to-next-LOAD period = SLOT_CYC+2 clocks; one frame occupies 5*(SLOT_CYC+2) clocks after ARB.
REQ-021 DONE (1 cycle): busy=0, then go to IDLE; back-to-back requests therefore cost exactly 2 idle clocks (DONE, IDLE) before the next ARB.
REQ-022 Requests arriving during a frame are not granted until the frame completes; the latched frame is immune to later frame/req changes.
REQ-023 Simultaneous requests: exactly one grant per ARB; no requester is granted twice while another with req held is waiting.
REQ-024 Slot counter is 16 bits; SLOT_CYC SHALL be >= 2.

Reset
REQ-025 Asynchronous reset forces state=IDLE, last_grant=2 (requester 0 wins first), byte_idx=0, counter=0, latched frame=0.
REQ-026 Reset forces outputs grant=0, busy=0, tx_byte=8'h00, tx_byte_en=0.
REQ-027 Reset mid-frame abandons the frame with no further tx_byte_en pulse; operation resumes from IDLE after release.

Structure
REQ-028 Shared package uart_pkg holds FRAME_W=40, NUM_BYTES=5, NUM_REQ=3 and the FSM state encoding.
REQ-029 Round-robin selection lives in one sub-module rr_pick (req, last_grant -> winner, valid), purely combinational.
REQ-030 uart_send is instantiated by the parent, not inside this block.

Verification (SLOT_CYC=20)
REQ-031 Single frame: req=3'b001, frame[39:0]=40'h01_02_A5B6C7 -> grant=001 once; tx_byte_en pulses carry 01,02,A5,B6,C7; pulses 22 clocks apart; busy low 1 cycle after the 5th slot.
REQ-032 Contention: req=3'b111 held from reset release -> grant order 001, 010, 100; each frame emits its own 5 bytes.
REQ-033 Fairness: req0 held continuously, req2 held continuously -> grants alternate 001, 100, 001, 100.
REQ-034 Mid-frame change: during byte 2, change frame[39:0] and assert req1 -> remaining bytes of the current frame are unchanged; req1 is granted 2 clocks after DONE.
REQ-035 Reset during WAIT of byte 3 -> all outputs 0 immediately; no further tx_byte_en; next req=3'b010 is granted normally.
REQ-036 Withdrawn request: req pulse of 1 cycle -> ARB entered, no grant, return to IDLE; tx_byte_en stays 0.
